// File: rtl/vend_pkg.sv
// Shared definitions for the two-panel vending arbiter: state encoding,
// coin codes and the default session timeout.
package vend_pkg;

  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ABORT   = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_ONE  = 2'd1;
  localparam logic [1:0] COIN_TWO  = 2'd2;

  // Code 3 is illegal and behaves exactly like no coin.
  function automatic logic coin_counts(input logic [1:0] c);
    return (c == COIN_ONE) || (c == COIN_TWO);
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle counter for a granted session; expired flags the last allowed
// zero-coin cycle.
module vend_timeout_ctr
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one vending core between two coin panels,
// with per-session timeout and core reset on abort.
module vend_arbiter
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  input  logic       product,
  input  logic       change,
  output logic [1:0] core_in,
  output logic       core_rst,
  output logic [1:0] grant,
  output logic [1:0] done_prod,
  output logic [1:0] done_chg,
  output logic [1:0] aborted
);

  vend_state_e state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;       // index of panel served last
  logic [1:0]  core_in_q, core_in_d;
  logic        core_rst_q, core_rst_d;
  logic [1:0]  done_prod_q, done_prod_d;
  logic [1:0]  done_chg_q, done_chg_d;
  logic [1:0]  aborted_q, aborted_d;

  logic [1:0]  sel_coin;
  logic        coin_live;
  logic        pick1;
  logic        ctr_clr, ctr_inc, ctr_expired;
  logic        timeout;

  assign sel_coin  = grant_q[1] ? coin1 : coin0;
  assign coin_live = coin_counts(sel_coin);
  assign timeout   = ctr_expired && !coin_live;
  // Panel 1 wins when alone, or when both ask and panel 0 went last.
  assign pick1     = req[1] && (!req[0] || !last_q);

  vend_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clr),
    .inc     (ctr_inc),
    .expired (ctr_expired)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    core_in_d   = COIN_NONE;
    core_rst_d  = 1'b0;
    done_prod_d = '0;
    done_chg_d  = '0;
    aborted_d   = '0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (req != 2'b00) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          state_d = ST_SERVE;
          ctr_clr = 1'b1;
        end
      end
      ST_SERVE: begin
        ctr_clr = coin_live;
        ctr_inc = !coin_live;
        // Product beats a simultaneous timeout.
        if (product) begin
          done_prod_d = grant_q;
          done_chg_d  = change ? grant_q : 2'b00;
          state_d     = ST_RELEASE;
        end else if (timeout) begin
          aborted_d  = grant_q;
          core_rst_d = 1'b1;
          state_d    = ST_ABORT;
        end else begin
          core_in_d = coin_live ? sel_coin : COIN_NONE;
        end
      end
      ST_RELEASE, ST_ABORT: begin
        grant_d = '0;
        last_d  = grant_q[1];
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= 1'b1;
      core_in_q   <= COIN_NONE;
      core_rst_q  <= 1'b1;
      done_prod_q <= '0;
      done_chg_q  <= '0;
      aborted_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      core_in_q   <= core_in_d;
      core_rst_q  <= core_rst_d;
      done_prod_q <= done_prod_d;
      done_chg_q  <= done_chg_d;
      aborted_q   <= aborted_d;
    end
  end

  assign core_in   = core_in_q;
  assign core_rst  = core_rst_q;
  assign grant     = grant_q;
  assign done_prod = done_prod_q;
  assign done_chg  = done_chg_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed bench for vend_arbiter: arbitration, coin forwarding, product,
// timeout, illegal coins and mid-session reset.
module tb_vend_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0, coin0 = '0, coin1 = '0;
  logic       product = 1'b0, change = 1'b0;
  logic [1:0] core_in, grant, done_prod, done_chg, aborted;
  logic       core_rst;

  int nchk = 0;
  int nerr = 0;

  vend_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .coin0     (coin0),
    .coin1     (coin1),
    .product   (product),
    .change    (change),
    .core_in   (core_in),
    .core_rst  (core_rst),
    .grant     (grant),
    .done_prod (done_prod),
    .done_chg  (done_chg),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic [1:0] ci,
                         input logic cr, input logic [1:0] dp, input logic [1:0] dc,
                         input logic [1:0] ab);
    chk({tag, ".grant"},     grant,     g);
    chk({tag, ".core_in"},   core_in,   ci);
    chk({tag, ".core_rst"},  core_rst,  cr);
    chk({tag, ".done_prod"}, done_prod, dp);
    chk({tag, ".done_chg"},  done_chg,  dc);
    chk({tag, ".aborted"},   aborted,   ab);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b0; tick; tick;
    chk_all("rst", 2'b00, 2'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    rst = 1'b1; tick;
    chk_all("idle", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);

    // Lone panel 0, coins 1,2 with one-cycle latency, product without change
    req = 2'b01; tick;
    chk_all("t1.grant", 2'b01, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    req = 2'b00; coin0 = 2'd1; tick;
    chk("t1.ci1", core_in, 2'd1);
    coin0 = 2'd2; tick;
    chk("t1.ci2", core_in, 2'd2);
    chk("t1.grant_held", grant, 2'b01);
    coin0 = 2'd0; product = 1'b1; tick;
    chk_all("t1.prod", 2'b01, 2'd0, 1'b0, 2'b01, 2'b00, 2'b00);
    product = 1'b0; tick;
    chk_all("t1.idle", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);

    // Both request after reset: panel 0 first, then panel 1
    rst = 1'b0; tick;
    rst = 1'b1; req = 2'b11; tick;
    chk("t2.first", grant, 2'b01);
    coin1 = 2'd2; tick;
    chk("t2.ignore_other", core_in, 2'd0);
    coin1 = 2'd0; product = 1'b1; tick;
    chk("t2.prod", done_prod, 2'b01);
    product = 1'b0; tick;
    chk("t2.idle", grant, 2'b00);
    tick;
    chk("t2.second", grant, 2'b10);

    // Panel 1 session, product and change together
    req = 2'b00; coin1 = 2'd2; tick;
    chk("t3.ci_a", core_in, 2'd2);
    tick;
    chk("t3.ci_b", core_in, 2'd2);
    coin1 = 2'd0; product = 1'b1; change = 1'b1; tick;
    chk_all("t3.prod", 2'b10, 2'd0, 1'b0, 2'b10, 2'b10, 2'b00);
    product = 1'b0; change = 1'b0; tick;
    chk("t3.idle", grant, 2'b00);

    // Timeout: coin 1, then 16 zero-coin cycles
    req = 2'b01; tick;
    chk("t4.grant", grant, 2'b01);
    req = 2'b00; coin0 = 2'd1; tick;
    chk("t4.ci", core_in, 2'd1);
    coin0 = 2'd0;
    repeat (15) tick;
    chk_all("t4.pre", 2'b01, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    tick;
    chk_all("t4.abort", 2'b01, 2'd0, 1'b1, 2'b00, 2'b00, 2'b01);
    tick;
    chk_all("t4.after", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    product = 1'b1; change = 1'b1; tick;
    chk_all("t4.stray", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    product = 1'b0; change = 1'b0;

    // Illegal coin, then reset mid-session
    req = 2'b01; tick;
    chk("t5.grant", grant, 2'b01);
    req = 2'b00; coin0 = 2'd1; tick;
    chk("t5.ci", core_in, 2'd1);
    coin0 = 2'd3; tick;
    chk("t5.illegal", core_in, 2'd0);
    rst = 1'b0; tick;
    chk_all("t5.rst", 2'b00, 2'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    rst = 1'b1; coin0 = 2'd0; tick;
    chk_all("t5.post", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);

    // Product at the timeout edge; illegal coins count as zero-coin cycles
    req = 2'b01; tick;
    chk("t6.grant", grant, 2'b01);
    req = 2'b00; coin0 = 2'd3;
    repeat (15) tick;
    chk_all("t6.pre", 2'b01, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    product = 1'b1; tick;
    chk_all("t6.prod", 2'b01, 2'd0, 1'b0, 2'b01, 2'b00, 2'b00);
    product = 1'b0; coin0 = 2'd0; tick;
    chk_all("t6.idle", 2'b00, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00);

    // Lone panel 0 wins even though it was served last
    req = 2'b01; tick;
    chk("t7.lone", grant, 2'b01);
    req = 2'b00; product = 1'b1; tick;
    product = 1'b0; tick;
    chk("t7.idle", grant, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: consecutive zero-coin cycles allowed before a granted session aborts.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-004 req  input  2  per-panel service request; bit 0 = panel 0, bit 1 = panel 1.
REQ-005 coin0  input  2  panel 0 coin code: 0 = none, 1 = one unit, 2 = two units, 3 = illegal.
REQ-006 coin1  input  2  panel 1 coin code, same encoding as coin0.
REQ-007 product  input  1  product pulse from the shared vending_machine core.
REQ-008 change  input  1  change pulse from the shared vending_machine core.
REQ-009 core_in  output  2  coin code forwarded to the core.
REQ-010 core_rst  output  1  active-high reset to the core.
REQ-011 grant  output  2  one-hot owner of the core; 0 when idle.
REQ-012 done_prod  output  2  one-cycle pulse to the owning panel: product dispensed.
REQ-013 done_chg  output  2  one-cycle pulse to the owning panel, coincident with done_prod: change returned.
REQ-014 aborted  output  2  one-cycle pulse to the owning panel: session timed out.

Function
REQ-015 States: IDLE, SERVE, RELEASE, ABORT.
REQ-016 IDLE: core_in = 0 and grant = 0; if req != 0, pick the winner by round-robin, set grant one-hot and enter SERVE on the next edge.
REQ-017 Round-robin: the panel not served last wins when both request; a lone requester always wins.
REQ-018 SERVE: core_in is registered from the granted panel's coin, giving 1-cycle latency; the other panel's coin is ignored.
REQ-019 Illegal coin code 3 is forwarded as 0 and counts as a zero-coin cycle.
REQ-020 Timeout counter clears on entry to SERVE and on every nonzero legal coin, and increments on every zero-coin cycle.
REQ-021 Product seen in SERVE: pulse done_prod[g] in the next cycle; done_chg[g] = change sampled with product; go to RELEASE.
REQ-022 RELEASE lasts one cycle with core_in = 0, then goes to IDLE; the last-served pointer becomes g; grant clears on IDLE entry.
REQ-023 Counter reaches TIMEOUT_CYC-1 in SERVE without product: go to ABORT.
REQ-024 ABORT lasts one cycle with core_rst = 1, aborted[g] = 1 and core_in = 0, then goes to IDLE; the pointer updates to g.
REQ-025 If product and timeout occur in the same cycle, product wins.
REQ-026 Deasserting req during SERVE has no effect; the session ends only via product or timeout.
REQ-027 product or change arriving outside SERVE is ignored.
REQ-028 core_rst is 0 in every state except ABORT and reset.

Reset
REQ-029 While rst = 0: state = IDLE, grant = 0, core_in = 0, done_prod = done_chg = aborted = 0, counter = 0, core_rst = 1, last-served pointer = panel 1.
REQ-030 Reset taking effect mid-session discards the session with no done or aborted pulse.

Structure
REQ-031 Shared package vend_pkg holds the state encoding, the coin codes (NONE/ONE/TWO), and the TIMEOUT_CYC default.
REQ-032 The timeout counter is sub-module vend_timeout_ctr (clear, inc, expired), sized $clog2(TIMEOUT_CYC).

Verification
REQ-033 Only req = 01; coin0 sequence 1, 2 -> grant = 01, core_in = 1, 2 one cycle later; core product -> done_prod = 01, done_chg = 00.
REQ-034 req = 11 after reset -> panel 0 is served first; after RELEASE, with req = 11 still held -> grant = 10.
REQ-035 Panel 1 granted; coin1 = 2, 2 -> core raises product and change together -> done_prod = 10 and done_chg = 10 in the same cycle.
REQ-036 Panel 0 granted; coin0 = 1 then 0 for 16 cycles -> aborted = 01 with one-cycle core_rst = 1; next cycle grant = 00.
REQ-037 Mid-SERVE, drive coin0 = 3 and rst = 0 for one cycle -> core_in = 0; all outputs reset; core_rst = 1; no done or aborted pulse.
REQ-038 product at the same edge as timeout expiry -> done_prod pulse, no aborted pulse.
